stream_demux: RTL and testbench



---
 rtl/stream_demux.sv | 176 +++++++++++++++++
 tb/tb_stream_demux.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// stream_demux: registered, packet-aware valid/ready demultiplexer routing one input stream to WIDTH outputs.
// Define STREAM_DEMUX_DROP_CNT_EN to add the saturating drop_count output for invalid-select packets.
module stream_demux #(
  parameter  int WIDTH     = 2,
  parameter  int SIZE      = 1,
  localparam int SEL_WIDTH = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SIZE-1:0]      in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [SEL_WIDTH-1:0] in_sel,
  output logic                 in_ready,
  output logic [SIZE-1:0]      out_data [WIDTH],
  output logic [WIDTH-1:0]     out_valid,
  output logic [WIDTH-1:0]     out_last,
  input  logic [WIDTH-1:0]     out_ready
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]          drop_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PKT  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [SEL_WIDTH:0] LP_SEL_LIMIT = (SEL_WIDTH+1)'(WIDTH);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SEL_WIDTH-1:0] r_lock_dest;
  logic [SIZE-1:0]      r_data;
  logic                 r_last;
  logic [SEL_WIDTH-1:0] r_dest;
  logic                 r_valid;

  logic                 w_sel_ok;
  logic                 w_dest_ready;
  logic                 w_free;
  logic                 w_route;
  logic [SEL_WIDTH-1:0] w_route_dest;

  // Select validity only matters when WIDTH is not a power of two.
  assign w_sel_ok = ({1'b0, in_sel} < LP_SEL_LIMIT);

  // Ready of the port currently owning the output register.
  always_comb begin
    w_dest_ready = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_dest_ready = w_dest_ready | (out_ready[i] & (r_dest == SEL_WIDTH'(i)));
    end
  end

  assign w_free = !r_valid || w_dest_ready;

  // Next-state, input ready and routing decision.
  always_comb begin
    w_state_nxt  = r_state;
    in_ready     = w_free;
    w_route      = 1'b0;
    w_route_dest = r_lock_dest;
    case (r_state)
      S_IDLE: begin
        w_route_dest = in_sel;
        if (w_sel_ok) begin
          in_ready = w_free;
          w_route  = in_valid && w_free;
          if (in_valid && w_free && !in_last) begin
            w_state_nxt = S_PKT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          // Invalid destination: swallow the whole packet without stalling.
          in_ready = 1'b1;
          if (in_valid && !in_last) begin
            w_state_nxt = S_DROP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_PKT: begin
        in_ready = w_free;
        w_route  = in_valid && w_free;
        if (in_valid && w_free && in_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_PKT;
        end
      end
      S_DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DROP;
        end
      end
      default: begin
        in_ready    = w_free;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Destination lock, captured from the first beat of a routed packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_dest <= '0;
    end else if (w_route && (r_state == S_IDLE)) begin
      r_lock_dest <= in_sel;
    end
  end

  // Output register: load on routed beat, otherwise drain on the owner's ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_dest  <= '0;
    end else if (w_route) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
      r_last  <= in_last;
      r_dest  <= w_route_dest;
    end else if (w_dest_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Fan the shared register out; valid and last are decoded by destination.
  always_comb begin
    out_valid = '0;
    out_last  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_data[i]  = r_data;
      out_valid[i] = r_valid && (r_dest == SEL_WIDTH'(i));
      out_last[i]  = r_valid && r_last && (r_dest == SEL_WIDTH'(i));
    end
  end

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic        w_drop_first;
  logic [15:0] r_drop_count;

  // In IDLE with an invalid select the input is always ready, so valid alone means accepted.
  assign w_drop_first = in_valid && (r_state == S_IDLE) && !w_sel_ok;

  // Saturating count of discarded packets.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_count <= 16'h0000;
    end else if (w_drop_first && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'h0001;
    end
  end

  assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux (WIDTH=3, SIZE=8): directed test-plan cases, then random traffic
// compared against a packet-level behavioural model.
module tb_stream_demux;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic [1:0] in_sel;
  logic       in_ready;
  logic [7:0] out_data [3];
  logic [2:0] out_valid;
  logic [2:0] out_last;
  logic [2:0] out_ready;
`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int n_cmp;
  int n_bad;

  // Model: one-entry output buffer plus packet mode (0 = between packets, 1 = routing, 2 = discarding).
  bit         m_valid;
  int         m_dest;
  logic [7:0] m_data;
  bit         m_last;
  int         m_mode;
  int         m_lock;
  int         m_drops;

  stream_demux #(.WIDTH(3), .SIZE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_sel    (in_sel),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_dest  = 0;
    m_data  = 8'h00;
    m_last  = 1'b0;
    m_mode  = 0;
    m_lock  = 0;
    m_drops = 0;
  endtask

  // One cycle: drive inputs after the falling edge, compare against the model, then advance the model.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input logic [1:0] s,
                      input logic [2:0] r, input bit rs);
    logic [2:0] ev;
    logic [2:0] el;
    bit sel_ok, free, exp_rdy, acc, drained;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    in_sel    = s;
    out_ready = r;
    rst       = rs;
    #1;
    ev = 3'b000;
    el = 3'b000;
    if (m_valid) begin
      ev[m_dest] = 1'b1;
      el[m_dest] = m_last;
    end
    sel_ok  = (int'(s) < 3);
    free    = !m_valid || r[m_dest];
    exp_rdy = ((m_mode == 0) && !sel_ok) || (m_mode == 2) || free;
    check("in_ready",  32'(in_ready),  32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(ev));
    check("out_last",  32'(out_last),  32'(el));
    for (int i = 0; i < 3; i++) begin
      check("out_data", 32'(out_data[i]), 32'(m_data));
    end
`ifdef STREAM_DEMUX_DROP_CNT_EN
    check("drop_count", 32'(drop_count), 32'(m_drops));
`endif
    acc     = v && exp_rdy;
    drained = m_valid && r[m_dest];
    if (rs) begin
      model_reset();
    end else if (acc && (m_mode == 0) && sel_ok) begin
      m_valid = 1'b1;
      m_dest  = int'(s);
      m_lock  = int'(s);
      m_data  = d;
      m_last  = l;
      m_mode  = l ? 0 : 1;
    end else if (acc && (m_mode == 1)) begin
      m_valid = 1'b1;
      m_dest  = m_lock;
      m_data  = d;
      m_last  = l;
      m_mode  = l ? 0 : 1;
    end else begin
      if (drained) m_valid = 1'b0;
      if (acc && (m_mode == 0)) begin
        if (m_drops < 65535) m_drops++;
        m_mode = l ? 0 : 2;
      end else if (acc && (m_mode == 2)) begin
        m_mode = l ? 0 : 2;
      end
    end
  endtask

  // Let the edge that commits the last step's inputs pass, then sample.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    in_sel    = 2'd0;
    out_ready = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);

    // 1: reset state with idle inputs
    step(1'b0, 8'h00, 1'b0, 2'd0, 3'b000, 1'b0);
    check("t1_out_valid", 32'(out_valid), 32'd0);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    step(1'b0, 8'h00, 1'b0, 2'd0, 3'b000, 1'b0);

    // 2: three-beat packet to port 2, in_sel changes after the first beat
    step(1'b1, 8'h11, 1'b0, 2'd2, 3'b111, 1'b0);
    step(1'b1, 8'h22, 1'b0, 2'd0, 3'b111, 1'b0);
    step(1'b1, 8'h33, 1'b1, 2'd0, 3'b111, 1'b0);
    settle();
    check("t2_valid", 32'(out_valid), 32'h4);
    check("t2_last", 32'(out_last), 32'h4);
    check("t2_data", 32'(out_data[2]), 32'h33);

    // 3: back-to-back single-beat packets to each port
    step(1'b1, 8'hA0, 1'b1, 2'd0, 3'b111, 1'b0);
    step(1'b1, 8'hA1, 1'b1, 2'd1, 3'b111, 1'b0);
    step(1'b1, 8'hA2, 1'b1, 2'd2, 3'b111, 1'b0);
    step(1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b0);
    step(1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b0);

    // 4: port 1 stalls while other ports toggle ready
    step(1'b1, 8'h41, 1'b0, 2'd1, 3'b111, 1'b0);
    step(1'b1, 8'h42, 1'b1, 2'd1, 3'b101, 1'b0);
    step(1'b1, 8'h42, 1'b1, 2'd1, 3'b000, 1'b0);
    check("t4_hold_data", 32'(out_data[1]), 32'h41);
    check("t4_stall", 32'(in_ready), 32'd0);
    step(1'b1, 8'h42, 1'b1, 2'd1, 3'b001, 1'b0);
    step(1'b1, 8'h42, 1'b1, 2'd1, 3'b100, 1'b0);
    step(1'b1, 8'h42, 1'b1, 2'd1, 3'b111, 1'b0);
    settle();
    check("t4_resume", 32'(out_data[1]), 32'h42);
    step(1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b0);

    // 5: invalid-select packet is swallowed, next packet routes normally
    step(1'b1, 8'h01, 1'b0, 2'd3, 3'b111, 1'b0);
    step(1'b1, 8'h02, 1'b0, 2'd0, 3'b111, 1'b0);
    step(1'b1, 8'h03, 1'b1, 2'd1, 3'b111, 1'b0);
    step(1'b1, 8'h5C, 1'b1, 2'd1, 3'b111, 1'b0);
    settle();
    check("t5_valid", 32'(out_valid), 32'h2);
    check("t5_data", 32'(out_data[1]), 32'h5C);
`ifdef STREAM_DEMUX_DROP_CNT_EN
    check("t5_drops", 32'(drop_count), 32'd1);
`endif
    step(1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b0);

    // 6: reset in the middle of a packet to port 2
    step(1'b1, 8'hB0, 1'b0, 2'd2, 3'b000, 1'b0);
    step(1'b1, 8'hB1, 1'b0, 2'd0, 3'b100, 1'b0);
    step(1'b0, 8'h00, 1'b0, 2'd0, 3'b000, 1'b1);
    settle();
    check("t6_cleared", 32'(out_valid), 32'd0);
    check("t6_data_zero", 32'(out_data[2]), 32'd0);
    step(1'b1, 8'hC0, 1'b1, 2'd0, 3'b000, 1'b0);
    settle();
    check("t6_reroute", 32'(out_valid), 32'h1);
    check("t6_data", 32'(out_data[0]), 32'hC0);
    step(1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b0);

    // Random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), ($urandom_range(0, 99) == 0));
    end
    step(1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
